// File: rtl/edge_monitor.sv
// edge_monitor: per-channel input synchroniser, stability filter and edge
// detector. Accepted edges raise one-cycle pulses, set a sticky status flag
// and bump a saturating per-channel edge counter. irq is the OR of status.
module edge_monitor #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH-1:0]       data_in,
  input  logic [2*CH-1:0]     mode,
  input  logic [CH-1:0]       clr,
  output logic [CH-1:0]       level_out,
  output logic [CH-1:0]       rise_pulse,
  output logic [CH-1:0]       fall_pulse,
  output logic [CH-1:0]       status,
  output logic                irq,
  output logic [CH*CNT_W-1:0] edge_count
);

  // Filter count value on which a pending level change is accepted.
  localparam logic [7:0]       FILT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Synchroniser chain: stage 0 samples the raw pins, last stage feeds the filter.
  logic [CH-1:0]    sync_q [SYNC_STAGES];
  logic [CH-1:0]    sync_s;

  // Filter state.
  logic [7:0]       fcnt_q [CH];
  logic [7:0]       fcnt_d [CH];
  logic [CH-1:0]    filt_q;
  logic [CH-1:0]    filt_d;
  logic [CH-1:0]    accept_s;

  // Event outputs and bookkeeping.
  logic [CH-1:0]    rise_q;
  logic [CH-1:0]    rise_d;
  logic [CH-1:0]    fall_q;
  logic [CH-1:0]    fall_d;
  logic [CH-1:0]    set_s;
  logic [CH-1:0]    status_q;
  logic [CH-1:0]    status_d;
  logic [CNT_W-1:0] cnt_q [CH];
  logic [CNT_W-1:0] cnt_d [CH];

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Shift raw inputs through the synchroniser flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= {CH{1'b0}};
      end
    end else begin
      sync_q[0] <= data_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Stability filter: count cycles the synchronised input disagrees with the
  // filtered level; the disagreement must persist FILTER_LEN cycles to be
  // accepted, and any agreeing cycle restarts the count.
  always_comb begin
    filt_d   = filt_q;
    accept_s = {CH{1'b0}};
    for (int i = 0; i < CH; i++) begin
      fcnt_d[i] = fcnt_q[i];
      if (sync_s[i] == filt_q[i]) begin
        fcnt_d[i] = 8'd0;
      end else if (fcnt_q[i] >= FILT_LAST) begin
        accept_s[i] = 1'b1;
        filt_d[i]   = sync_s[i];
        fcnt_d[i]   = 8'd0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + 8'd1;
      end
    end
  end

  // Pulse qualification by the mode sampled on the accept edge, plus the
  // sticky status and saturating counter updates (a pulse beats clr).
  always_comb begin
    rise_d   = {CH{1'b0}};
    fall_d   = {CH{1'b0}};
    set_s    = {CH{1'b0}};
    status_d = status_q;
    for (int i = 0; i < CH; i++) begin
      rise_d[i] = accept_s[i] &  sync_s[i] & mode[2*i];
      fall_d[i] = accept_s[i] & ~sync_s[i] & mode[2*i+1];
      set_s[i]  = rise_d[i] | fall_d[i];

      if (set_s[i]) begin
        status_d[i] = 1'b1;
      end else if (clr[i]) begin
        status_d[i] = 1'b0;
      end else begin
        status_d[i] = status_q[i];
      end

      case ({clr[i], set_s[i]})
        2'b10:   cnt_d[i] = {CNT_W{1'b0}};
        2'b11:   cnt_d[i] = CNT_ONE;
        2'b01: begin
          if (cnt_q[i] != CNT_MAX) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end else begin
            cnt_d[i] = cnt_q[i];
          end
        end
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // State register for filter, pulses, status and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q   <= {CH{1'b0}};
      rise_q   <= {CH{1'b0}};
      fall_q   <= {CH{1'b0}};
      status_q <= {CH{1'b0}};
      for (int i = 0; i < CH; i++) begin
        fcnt_q[i] <= 8'd0;
        cnt_q[i]  <= {CNT_W{1'b0}};
      end
    end else begin
      filt_q   <= filt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      status_q <= status_d;
      for (int i = 0; i < CH; i++) begin
        fcnt_q[i] <= fcnt_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  // Flatten the per-channel counters onto the output bus.
  always_comb begin
    edge_count = {(CH*CNT_W){1'b0}};
    for (int i = 0; i < CH; i++) begin
      edge_count[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign level_out  = filt_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign status     = status_q;
  assign irq        = |status_q;

endmodule

// File: tb/tb_edge_monitor.sv
// Self-checking bench for edge_monitor: directed scenarios followed by a
// randomized run, all compared against a history-window reference model.
module tb_edge_monitor;

  localparam int CH    = 4;
  localparam int SYNC  = 2;
  localparam int FILT  = 4;
  localparam int CNT_W = 3;
  localparam int HLEN  = SYNC + FILT;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [CH-1:0]       data_in;
  logic [2*CH-1:0]     mode;
  logic [CH-1:0]       clr;
  logic [CH-1:0]       level_out;
  logic [CH-1:0]       rise_pulse;
  logic [CH-1:0]       fall_pulse;
  logic [CH-1:0]       status;
  logic                irq;
  logic [CH*CNT_W-1:0] edge_count;

  int n_checks = 0;
  int n_errors = 0;

  edge_monitor #(.CH(CH), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .mode(mode), .clr(clr),
    .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .status(status), .irq(irq), .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  // Reference model: hist[k] is the data_in sampled k edges ago.
  logic [CH-1:0] hist[$];
  logic [CH-1:0] filt_m, rise_m, fall_m, status_m;
  int            cnt_m [CH];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < HLEN; k++) hist.push_back({CH{1'b0}});
    filt_m = '0; rise_m = '0; fall_m = '0; status_m = '0;
    for (int i = 0; i < CH; i++) cnt_m[i] = 0;
  endtask

  // A level change is accepted when the last FILT synchronised samples seen
  // by the filter all disagree with the current filtered level.
  task automatic model_edge();
    bit acc, nl, ev;
    if (!rst_n) begin
      model_reset();
    end else begin
      hist.push_front(data_in);
      void'(hist.pop_back());
      for (int i = 0; i < CH; i++) begin
        acc = 1'b1;
        for (int j = 0; j < FILT; j++) begin
          if (hist[SYNC + j][i] == filt_m[i]) acc = 1'b0;
        end
        rise_m[i] = 1'b0;
        fall_m[i] = 1'b0;
        if (acc) begin
          nl = ~filt_m[i];
          filt_m[i] = nl;
          rise_m[i] = nl & mode[2*i];
          fall_m[i] = ~nl & mode[2*i+1];
        end
        ev = rise_m[i] | fall_m[i];
        if (clr[i]) begin
          cnt_m[i]    = ev ? 1 : 0;
          status_m[i] = ev;
        end else if (ev) begin
          cnt_m[i]    = (cnt_m[i] < CMAX) ? cnt_m[i] + 1 : CMAX;
          status_m[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [CH*CNT_W-1:0] exp_cnt;
    for (int i = 0; i < CH; i++) exp_cnt[i*CNT_W +: CNT_W] = cnt_m[i][CNT_W-1:0];
    check_eq("level", level_out, filt_m);
    check_eq("rise", rise_pulse, rise_m);
    check_eq("fall", fall_pulse, fall_m);
    check_eq("status", status, status_m);
    check_eq("irq", irq, |status_m);
    check_eq("count", edge_count, exp_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic step_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic pulse_clr(input logic [CH-1:0] m);
    clr = m;
    step();
    clr = '0;
  endtask

  // Bound the whole run.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, seen;
    int run_len [CH];

    rst_n = 1'b0; data_in = '0; mode = '0; clr = '0;
    model_reset();
    #1;
    compare_all();
    step_n(2);
    rst_n = 1'b1;

    // Single rise on ch0, mode rise-only: pulse at edge 6.
    mode = 8'b00_00_00_01;
    step_n(3);
    data_in[0] = 1'b1;
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (first < 0 && rise_pulse[0]) first = k;
    end
    check_eq("rise_latency", first, 6);
    check_eq("cnt0_one", edge_count[CNT_W-1:0], 1);
    check_eq("irq_set", irq, 1);

    // Glitch of 3 cycles is filtered out.
    data_in[0] = 1'b0;
    step_n(10);
    pulse_clr(4'b0001);
    data_in[0] = 1'b1;
    step_n(3);
    data_in[0] = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (rise_pulse[0] || level_out[0]) seen++;
    end
    check_eq("glitch_none", seen, 0);
    check_eq("glitch_cnt", edge_count[CNT_W-1:0], 0);

    // Both edges, then clr coincident with the 7th pulse.
    mode = 8'b00_00_00_11;
    for (int t = 0; t < 3; t++) begin
      data_in[0] = 1'b1; step_n(10);
      data_in[0] = 1'b0; step_n(10);
    end
    check_eq("both_cnt6", edge_count[CNT_W-1:0], 6);
    data_in[0] = 1'b1;
    step_n(5);
    clr[0] = 1'b1;
    step();
    clr = '0;
    check_eq("clr_pulse_cnt", edge_count[CNT_W-1:0], 1);
    check_eq("clr_pulse_status", status[0], 1);
    data_in[0] = 1'b0; step_n(10);

    // Saturation on ch0, mode-off tracking on ch1.
    mode = 8'b00_00_00_01;
    pulse_clr(4'b0001);
    for (int t = 0; t < 9; t++) begin
      data_in[0] = 1'b1; step_n(10);
      data_in[0] = 1'b0; step_n(10);
    end
    check_eq("sat_cnt", edge_count[CNT_W-1:0], CMAX);
    seen = 0;
    for (int t = 0; t < 3; t++) begin
      data_in[1] = 1'b1; step_n(10);
      check_eq("ch1_level_hi", level_out[1], 1);
      data_in[1] = 1'b0; step_n(10);
      check_eq("ch1_level_lo", level_out[1], 0);
    end
    check_eq("ch1_status", status[1], 0);
    check_eq("ch1_cnt", edge_count[2*CNT_W-1:CNT_W], 0);

    // Randomized run.
    for (int i = 0; i < CH; i++) run_len[i] = $urandom_range(1, 9);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < CH; i++) begin
        run_len[i]--;
        if (run_len[i] <= 0) begin
          data_in[i] = ~data_in[i];
          run_len[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 12);
        end
        clr[i] = ($urandom_range(0, 19) == 0);
      end
      if ($urandom_range(0, 15) == 0) mode = $urandom_range(0, (1 << (2*CH)) - 1);
      step();
    end
    clr = '0;

    // Inputs high through reset: all rise pulses together at edge 6.
    mode = '1;
    data_in = '1;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    step_n(3);
    rst_n = 1'b1;
    first = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (first < 0 && rise_pulse == {CH{1'b1}}) first = k;
    end
    check_eq("rst_rise_latency", first, 6);

    // Reset mid-filter clears everything asynchronously, no late pulse.
    data_in = '0;
    step_n(3);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check_eq("async_level", level_out, 0);
    check_eq("async_count", edge_count, 0);
    step_n(2);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (rise_pulse != '0 || fall_pulse != '0) seen++;
    end
    check_eq("no_late_pulse", seen, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/edge_monitor.md
EDGE_MONITOR -- requirements
Module: edge_monitor

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser flop depth per channel (2..4).
REQ-003 SHALL have parameter FILTER_LEN, default 4: consecutive stable cycles required to accept a level change (1..255).
REQ-004 SHALL have parameter CNT_W, default 8: width of each per-channel edge counter (1..16).
REQ-005 SHALL have port clk  input  1: single clock; all logic on posedge.
REQ-006 SHALL have port rst_n  input  1: reset, asynchronous assert and active-low; the only reset in the block.
REQ-007 SHALL have port data_in  input  CH: asynchronous raw inputs, bit i is channel i.
REQ-008 SHALL have port mode  input  2*CH: channel i mode is bits [2i+1:2i]; 00 off, 01 rise, 10 fall, 11 both.
REQ-009 SHALL have port clr  input  CH: write-1-to-clear strobe for channel i status and counter.
REQ-010 SHALL have port level_out  output  CH: filtered, synchronised level.
REQ-011 SHALL have port rise_pulse  output  CH: one-cycle pulse on accepted 0->1 when mode bit0=1.
REQ-012 SHALL have port fall_pulse  output  CH: one-cycle pulse on accepted 1->0 when mode bit1=1.
REQ-013 SHALL have port status  output  CH: sticky per-channel flag, set by any emitted pulse.
REQ-014 SHALL have port irq  output  1: OR-reduction of status.
REQ-015 SHALL have port edge_count  output  CH*CNT_W: channel i counter in bits [(i+1)*CNT_W-1:i*CNT_W].

Function
REQ-016 SHALL pass each data_in bit through a SYNC_STAGES-deep flop chain; sync[i] is the last stage.
REQ-017 SHALL keep per channel a filter counter (8 bits) and filtered level filt[i]; level_out = filt.
REQ-018 SHALL, when sync[i]==filt[i], clear the filter counter the same edge.
REQ-019 SHALL, when sync[i]!=filt[i] and counter < FILTER_LEN-1, increment counter.
REQ-020 SHALL, when sync[i]!=filt[i] and counter == FILTER_LEN-1 ("accept"), load filt[i]<=sync[i] and clear counter.
REQ-021 SHALL treat a glitch shorter than FILTER_LEN cycles at sync[i] as no event: filt, pulses, status, count unchanged.
REQ-022 SHALL register rise_pulse[i] <= accept & sync[i] & mode[2i], fall_pulse[i] <= accept & ~sync[i] & mode[2i+1]; pulses rise on the same edge filt changes and last exactly one cycle.
REQ-023 SHALL give total latency data_in change to pulse/level_out change = SYNC_STAGES+FILTER_LEN clock edges (6 at defaults).
REQ-024 SHALL keep filtering and level_out tracking active in mode 00; only pulses, status and count are suppressed.
REQ-025 SHALL sample mode at the accept edge; mode changes never generate or cancel a pulse otherwise.
REQ-026 SHALL set status[i] on the edge any pulse for channel i is registered; clr[i] clears it; simultaneous set and clr: status becomes 1.
REQ-027 SHALL increment edge_count channel i by 1 per emitted pulse, saturating at 2^CNT_W-1 (no wrap).
REQ-028 SHALL, on clr[i] alone, zero counter i; on clr[i] with simultaneous pulse, load counter i with 1.
REQ-029 SHALL drive irq combinationally from registered status, no extra latency.
REQ-030 SHALL keep channels fully independent; simultaneous events on all channels each handled in the same cycle.

Reset
REQ-031 SHALL, while rst_n=0, hold all sync stages, filt, filter counters, rise_pulse, fall_pulse, status, edge_count at 0; irq=0.
REQ-032 SHALL, because filt resets to 0, report an input held high through reset release as one rise after SYNC_STAGES+FILTER_LEN edges (if enabled).
REQ-033 SHALL abort any in-progress filter count on mid-operation reset; no pulse after release for the aborted transition except per REQ-032.

Verification
REQ-034 Defaults, mode=01 ch0, data_in[0] 0->1 held 20 cycles -> rise_pulse[0] high 1 cycle at edge 6, status[0]=1, irq=1, count0=1.
REQ-035 data_in[0] high 3 cycles then low (FILTER_LEN=4) -> no pulse, level_out[0] stays 0, count0=0.
REQ-036 mode=11, three clean high/low toggles of 10 cycles -> 3 rise + 3 fall pulses, count0=6; clr[0] same cycle as 7th pulse -> count0=1, status[0]=1.
REQ-037 CNT_W=2, mode=01, 5 clean rises -> count saturates at 3; mode=00 on ch1 with toggles -> level_out[1] follows, no pulses/status on ch1.
REQ-038 data_in all 1 through reset, rst_n released -> all enabled rise_pulse bits assert together at edge 6; rst_n dropped mid-filter -> all outputs 0 immediately, asynchronously.
